// File: rtl/multicycle_control_fsm_if.sv
// Control interface between the multi-cycle RV32I control FSM and the
// datapath / unified memory. The FSM side is the master: it consumes the
// instruction fields, ALU flag and memory handshake, and drives every
// datapath mux select and enable.
interface multicycle_control_fsm_if;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       zero;
  logic       mem_ready;
  logic       pc_write;
  logic       adr_src;
  logic       mem_write;
  logic       ir_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic       reg_write;
  logic [2:0] imm_src;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  opcode, funct3, zero, mem_ready,
    output pc_write, adr_src, mem_write, ir_write, result_src,
           alu_src_a, alu_src_b, alu_op, reg_write, imm_src, illegal, state
  );

  modport slave (
    output opcode, funct3, zero, mem_ready,
    input  pc_write, adr_src, mem_write, ir_write, result_src,
           alu_src_a, alu_src_b, alu_op, reg_write, imm_src, illegal, state
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Main control FSM of the multi-cycle RV32I core. Steps each instruction
// through fetch, decode, execute, memory and writeback, and drives the
// datapath selects/enables. Outputs are purely combinational from the
// current state (plus mem_ready, zero and funct3 where a state needs them).
module multicycle_control_fsm (
  input  logic                      clk,
  input  logic                      reset,
  multicycle_control_fsm_if.master  bus
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    JAL      = 4'd10,
    LUI      = 4'd11,
    ILLEGAL  = 4'd12
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  state_t state_q;
  state_t state_d;

  // State register: async reset abandons any instruction in flight.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples pre-edge values regardless of block ordering.
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  // Next-state and per-state datapath controls.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    state_d        = FETCH;
    bus.pc_write   = 1'b0;
    bus.adr_src    = 1'b0;
    bus.mem_write  = 1'b0;
    bus.ir_write   = 1'b0;
    bus.result_src = 2'b00;
    bus.alu_src_a  = 2'b00;
    bus.alu_src_b  = 2'b00;
    bus.alu_op     = 2'b00;
    bus.reg_write  = 1'b0;
    bus.illegal    = 1'b0;

    case (state_q)
      FETCH: begin
        // PC+4 computed on the ALU and written back while the word is latched.
        bus.alu_src_b  = 2'b10;
        bus.result_src = 2'b10;
        bus.ir_write   = bus.mem_ready;
        bus.pc_write   = bus.mem_ready;
        state_d        = bus.mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        // Speculatively form OldPC+imm into ALUOut for branch/jal targets.
        bus.alu_src_a = 2'b01;
        bus.alu_src_b = 2'b01;
        case (bus.opcode)
          OP_LOAD, OP_STORE: state_d = MEMADR;
          OP_RTYPE:          state_d = EXECUTER;
          OP_ITYPE:          state_d = EXECUTEI;
          OP_BRANCH:         state_d = BRANCH;
          OP_JAL:            state_d = JAL;
          OP_LUI:            state_d = LUI;
          default:           state_d = ILLEGAL;
        endcase
      end
      MEMADR: begin
        bus.alu_src_a = 2'b10;
        bus.alu_src_b = 2'b01;
        state_d       = (bus.opcode == OP_LOAD) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        bus.adr_src = 1'b1;
        state_d     = bus.mem_ready ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        bus.result_src = 2'b01;
        bus.reg_write  = 1'b1;
      end
      MEMWRITE: begin
        // Strobe held every cycle until memory accepts the write.
        bus.adr_src   = 1'b1;
        bus.mem_write = 1'b1;
        state_d       = bus.mem_ready ? FETCH : MEMWRITE;
      end
      EXECUTER: begin
        bus.alu_src_a = 2'b10;
        bus.alu_op    = 2'b10;
        state_d       = ALUWB;
      end
      EXECUTEI: begin
        bus.alu_src_a = 2'b10;
        bus.alu_src_b = 2'b01;
        bus.alu_op    = 2'b10;
        state_d       = ALUWB;
      end
      ALUWB: begin
        bus.reg_write = 1'b1;
      end
      BRANCH: begin
        // Compare rs1-rs2; target already sits in ALUOut from DECODE.
        bus.alu_src_a = 2'b10;
        bus.alu_op    = 2'b01;
        case (bus.funct3)
          3'b000:  bus.pc_write = bus.zero;
          3'b001:  bus.pc_write = ~bus.zero;
          default: bus.pc_write = 1'b0;
        endcase
      end
      JAL: begin
        // Jump to ALUOut target while computing OldPC+4 for the link.
        bus.alu_src_a = 2'b01;
        bus.alu_src_b = 2'b10;
        bus.pc_write  = 1'b1;
        state_d       = ALUWB;
      end
      LUI: begin
        bus.alu_src_a = 2'b11;
        bus.alu_src_b = 2'b01;
        state_d       = ALUWB;
      end
      ILLEGAL: begin
        bus.illegal = 1'b1;
        state_d     = ILLEGAL;
      end
      default: state_d = FETCH;
    endcase
  end

  // Immediate format select follows the opcode in every state.
  always_comb begin
    case (bus.opcode)
      OP_STORE:  bus.imm_src = 3'b001;
      OP_BRANCH: bus.imm_src = 3'b010;
      OP_JAL:    bus.imm_src = 3'b011;
      OP_LUI:    bus.imm_src = 3'b100;
      default:   bus.imm_src = 3'b000;
    endcase
  end

  assign bus.state = state_q;

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Main control state machine of the multi-cycle RV32I core. Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives the datapath mux and enable signals, including the 2-bit alu_op consumed by the ALU control decoder.
- Sits between the instruction register (opcode/funct3 in) and the datapath. It also holds a simple ready handshake with the unified instruction/data memory.

Parameters:
- none (state encoding and opcodes are fixed by RV32I; see Behaviour)

Ports:
- clk  in  1  single system clock, rising edge
- reset  in  1  asynchronous, active-high; forces state to FETCH immediately
- opcode  in  7  instr[6:0] from instruction register
- funct3  in  3  instr[14:12]; used only for branch sense
- zero  in  1  ALU zero flag, same cycle
- mem_ready  in  1  memory completes the current access this cycle
- pc_write  out  1  PC register enable
- adr_src  out  1  memory address: 0=PC, 1=result bus
- mem_write  out  1  memory write strobe
- ir_write  out  1  instruction register (and OldPC) enable
- result_src  out  2  00=ALUOut reg, 01=mem data reg, 10=ALU result
- alu_src_a  out  2  00=PC, 01=OldPC, 10=rs1 reg, 11=constant 0
- alu_src_b  out  2  00=rs2 reg, 01=ImmExt, 10=constant 4
- alu_op  out  2  00=ADD, 01=SUB (compare), 10=decode funct3/funct7
- reg_write  out  1  register file write enable
- imm_src  out  3  000=I, 001=S, 010=B, 011=J, 100=U
- illegal  out  1  sticky unsupported-opcode flag
- state  out  4  current state, for debug/verification

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9, JAL=10, LUI=11, ILLEGAL=12.
- Values 13-15 are unreachable; if ever entered, next state = FETCH.
- State register: asynchronous reset to FETCH; otherwise updates on the rising clk edge.
- Outputs are combinational from state, plus mem_ready/zero/funct3 where noted.
- Default for every output not listed for a state is 0.
- Reset mid-instruction abandons the instruction. No partial writes follow reset deassertion.
- Reset output values (state FETCH): adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10, illegal=0, state=0. ir_write and pc_write equal mem_ready.
- imm_src is combinational from opcode in every state:
  - lw, jalr-style I-ALU → 000
  - sw → 001
  - branch → 010
  - jal → 011
  - lui → 100
  - other → 000
- FETCH: as at reset. ir_write = pc_write = mem_ready. Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE: alu_src_a=01, alu_src_b=01, alu_op=00 (branch/jal target into ALUOut). Next state by opcode:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECUTER
  - 0010011 → EXECUTEI
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 0110111 → LUI
  - anything else → ILLEGAL
- MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00. Next state is MEMREAD if opcode=0000011, else MEMWRITE.
- MEMREAD: adr_src=1, result_src=00. Hold until mem_ready=1, then go to MEMWB.
- MEMWB: result_src=01, reg_write=1. Next state FETCH.
- MEMWRITE: adr_src=1, result_src=00, mem_write=1 every cycle until mem_ready=1, then go to FETCH. The strobe is held, not pulsed.
- EXECUTER: alu_src_a=10, alu_src_b=00, alu_op=10. Next state ALUWB.
- EXECUTEI: alu_src_a=10, alu_src_b=01, alu_op=10. Next state ALUWB.
- ALUWB: result_src=00, reg_write=1. Next state FETCH.
- BRANCH: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00.
  - funct3=000 (beq): pc_write = zero.
  - funct3=001 (bne): pc_write = ~zero.
  - Other funct3: pc_write=0, and the instruction is a no-op.
  - Next state FETCH.
- JAL: alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_write=1. Next state ALUWB (rd ← OldPC+4).
- LUI: alu_src_a=11, alu_src_b=01, alu_op=00. Next state ALUWB.
- ILLEGAL: all enables 0, illegal=1. Stays in ILLEGAL until reset.
- Never assert pc_write and mem_write together. Never assert reg_write and mem_write together.
- Cycle counts with mem_ready tied high: lw 5, sw 4, R/I 4, branch 3, jal 4, lui 4.

Test Plan:
- Reset asserted mid-MEMWRITE with mem_ready=0 → state=0 immediately (async, before the next edge), mem_write=0. After deassert, first edge with mem_ready=1 → state=1.
- lw (opcode 0000011), mem_ready=1 → state sequence 0,1,2,3,4,0. reg_write=1 only in state 4 with result_src=01. In state 3, adr_src=1.
- sw with mem_ready low for 3 cycles in MEMWRITE → mem_write=1 for 4 consecutive cycles, then state=0. reg_write never 1.
- beq with zero=1, then bne with zero=1 → pc_write=1 in BRANCH for beq and 0 for bne. Both have alu_op=01 and return to FETCH after 3 cycles.
- R-type add, then addi → alu_op=10 in states 6/7 with alu_src_b=00 and 01 respectively. Each then goes ALUWB→FETCH.
- opcode 1110011 → DECODE→ILLEGAL; illegal=1 and all enables 0 for 10+ cycles. Reset clears illegal to 0.
